// File: rtl/seq_logic_pkg.sv
// Shared encodings for the chunk-serial bitwise logic unit: operation codes,
// FSM states and a helper that sizes the chunk counter.
package seq_logic_pkg;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // A single-chunk configuration still needs a 1-bit counter.
  function automatic int cnt_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/chunk_logic.sv
// Combinational CHUNK-wide bitwise operator; the top reuses one instance for
// every chunk of an operation.
module chunk_logic
  import seq_logic_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  op_t              op,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [CHUNK-1:0] y
);

  always_comb begin
    y = '0;
    unique case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOR:  y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/seq_logic_unit.sv
// Chunk-serial bitwise logic unit: captures a, b and op on start, processes
// CHUNK bits per clock, publishes the whole word at once in DONE.
// Optional macro SEQ_LOGIC_PARITY_EN adds a registered parity output.
module seq_logic_unit
  import seq_logic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
`ifdef SEQ_LOGIC_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = cnt_width(NCH);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  op_t              op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] work, work_next;
  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_y;
  logic             last_chunk;
  logic             accept;
  int               base;

  always_comb begin
    base    = int'(cnt) * CHUNK;
    chunk_a = a_q[base +: CHUNK];
    chunk_b = b_q[base +: CHUNK];
  end

  chunk_logic #(.CHUNK(CHUNK)) u_chunk (
    .op (op_q),
    .a  (chunk_a),
    .b  (chunk_b),
    .y  (chunk_y)
  );

  assign last_chunk = (cnt == CW'(NCH - 1));
  assign accept     = start && (state == IDLE || state == DONE);
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    work_next  = work;
    work_next[base +: CHUNK] = chunk_y;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_chunk) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The final chunk is merged on the way into result so that result only ever
  // changes to a complete word, in the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      op_q   <= OP_AND;
      a_q    <= '0;
      b_q    <= '0;
      work   <= '0;
      result <= '0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= op_t'(op);
      a_q  <= a;
      b_q  <= b;
      work <= '0;
    end else if (state == RUN) begin
      cnt  <= cnt + CW'(1);
      work <= work_next;
      if (last_chunk) result <= work_next;
    end
  end

`ifdef SEQ_LOGIC_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                         parity <= 1'b0;
    else if (state == RUN && last_chunk) parity <= ^work_next;
  end
`endif

endmodule

// File: tb/tb_seq_logic_unit.sv
// Scoreboard bench for seq_logic_unit: stimulus pushes word-level expected
// results with their due cycle, a negedge monitor pops them on every done.
module tb_seq_logic_unit;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] result;

  logic        start16 = 1'b0;
  logic [1:0]  op16 = 2'b00;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16;
  logic [15:0] result16;
`ifdef SEQ_LOGIC_PARITY_EN
  logic        parity, parity16;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        par;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_res = '0;

  seq_logic_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result)
`ifdef SEQ_LOGIC_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  seq_logic_unit #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start16),
    .op     (op16),
    .a      (a16),
    .b      (b16),
    .busy   (busy16),
    .done   (done16),
    .result (result16)
`ifdef SEQ_LOGIC_PARITY_EN
    ,
    .parity (parity16)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Issue one start pulse; the expected word and its done cycle go on the queue.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                               input bit expect_done);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    if (expect_done) begin
      e.res = model(o, x, y);
      e.par = ^e.res;
      e.due = cyc + 1 + NCH;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    checkOutput("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("done_cycle", 32'(cyc), 32'(e.due));
        checkOutput("busy_in_done", {31'b0, busy}, 32'd0);
`ifdef SEQ_LOGIC_PARITY_EN
        checkOutput("parity", {31'b0, parity}, {31'b0, e.par});
`endif
        last_res = e.res;
      end
    end else begin
      checkOutput("result_hold", result, last_res);
    end
  end

  initial begin
    int c0, k;
    logic [31:0] ra, rb;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_busy", {31'b0, busy}, 32'd0);
    checkOutput("reset_done", {31'b0, done}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] directed vectors");
    applyStimulus(2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1);
    waitDrain();
    checkOutput("xor_vector", result, 32'hF0F00F0F);
    applyStimulus(2'b11, 32'h00000000, 32'h00000001, 1'b1);
    waitDrain();
    checkOutput("nor_vector", result, 32'hFFFFFFFE);
    applyStimulus(2'b00, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1);
    waitDrain();

    $display("[TB] start during run ignored");
    applyStimulus(2'b10, 32'hFFFF0000, 32'h0F0F0F0F, 1'b1);
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; op = 2'b01; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (NCH + 3) @(posedge clk);
    waitDrain();
    checkOutput("ignored_start_result", result, 32'hF0F00F0F);

    $display("[TB] back-to-back");
    for (int i = 0; i < 4 * (NCH + 1); i++) begin
      exp_t e;
      @(posedge clk); #1;
      if (i > 0)
        checkOutput("busy_b2b", {31'b0, busy}, {31'b0, ((i - 1) % (NCH + 1)) != NCH});
      start = 1'b1; op = 2'b01; a = $urandom; b = $urandom;
      if (i % (NCH + 1) == 0) begin
        e.res = model(op, a, b);
        e.par = ^e.res;
        e.due = cyc + 1 + NCH;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    waitDrain();

    $display("[TB] reset during run");
    applyStimulus(2'b01, 32'h12345678, 32'h0F0F0000, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    last_res = '0;
    rst_n = 1'b1;
    checkOutput("abort_result", result, 32'd0);
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    repeat (NCH + 3) @(posedge clk);
    applyStimulus(2'b10, 32'hDEADBEEF, 32'h01234567, 1'b1);
    waitDrain();

    $display("[TB] random operations");
    for (int i = 0; i < 20; i++) begin
      ra = $urandom; rb = $urandom;
      applyStimulus(2'($urandom_range(0, 3)), ra, rb, 1'b1);
      waitDrain();
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("[TB] single-chunk instance");
    @(posedge clk); #1;
    start16 = 1'b1; op16 = 2'b10; a16 = 16'h1234; b16 = 16'hFFFF;
    c0 = cyc;
    @(posedge clk); #1;
    start16 = 1'b0;
    k = 0;
    while (!done16 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("nch1_done_seen", {31'b0, done16}, 32'd1);
    checkOutput("nch1_done_cycle", 32'(cyc), 32'(c0 + 2));
    checkOutput("nch1_result", {16'b0, result16}, 32'h0000EDCB);
    repeat (3) @(posedge clk);

    waitDrain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_logic_unit.md
SEQ_LOGIC_UNIT -- requirements
Module: seq_logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, meaning bits processed per clock; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request a new operation.
REQ-006 SHALL have port op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port busy  output  1  operation in progress.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port result  output  WIDTH  last completed result.
REQ-012 SHALL have port parity  output  1  XOR-reduction of result (only with SEQ_LOGIC_PARITY_EN).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; NCH = WIDTH/CHUNK.
REQ-014 IDLE: start=1 SHALL capture a, b, op, clear chunk counter to 0, go RUN.
REQ-015 RUN: each cycle SHALL compute chunk [cnt*CHUNK +: CHUNK] of captured operands into working register, increment cnt; after chunk NCH-1 go DONE.
REQ-016 DONE: SHALL load result (and parity) from working register, assert done for exactly this cycle; start=1 here SHALL be accepted as in IDLE (back-to-back, next state RUN), else go IDLE.
REQ-017 Latency: done SHALL be high exactly NCH+1 clocks after the edge sampling start.
REQ-018 busy SHALL be 1 in RUN, 0 in IDLE and DONE.
REQ-019 start while in RUN SHALL be ignored; captured operands and op SHALL not change mid-operation.
REQ-020 result SHALL hold its value from one DONE until the next DONE; it SHALL never show partial chunks.
REQ-021 Counter SHALL be ceil(log2(NCH)) bits min 1; NCH=1 SHALL give one RUN cycle.
REQ-022 No arithmetic carries between chunks; each bit i of result SHALL equal op(a[i], b[i]) of captured operands.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force IDLE, cnt=0, busy=0, done=0, result=0, parity=0, working register=0.
REQ-024 Reset during RUN SHALL abort the operation without a done pulse; result SHALL read 0.

Configuration
REQ-025 Macro SEQ_LOGIC_PARITY_EN defined: parity port present, registered as ^result, updated in DONE together with result.
REQ-026 Macro undefined: parity port and its register SHALL be absent; all other behaviour identical.

Structure
REQ-027 Shared package seq_logic_pkg SHALL hold op encodings (OP_AND, OP_OR, OP_XOR, OP_NOR) and FSM state encodings.
REQ-028 Sub-module chunk_logic (CHUNK-wide, combinational, op-selected) SHALL compute one chunk; single instance, reused each RUN cycle.

Verification (WIDTH=32, CHUNK=8 unless stated)
REQ-029 op=10, a=0xFFFF0000, b=0x0F0F0F0F, start 1 cycle -> done at clock 5, result=0xF0F00F0F, parity=0.
REQ-030 op=11, a=0x00000000, b=0x00000001 -> result=0xFFFFFFFE, parity=1; op=00 a=b=0xA5A5A5A5 -> 0xA5A5A5A5.
REQ-031 start asserted again in cycles 2-4 with a=0xFFFFFFFF -> ignored, first result unchanged, single done pulse.
REQ-032 start held high continuously with op=01 -> done every 5 clocks, busy low only in DONE cycles, results in order.
REQ-033 rst_n=0 at clock 3 of RUN -> no done, result=0, busy=0; next start completes normally.
REQ-034 WIDTH=16, CHUNK=16, op=10, a=0x1234, b=0xFFFF -> done at clock 2, result=0xEDCB.
